dmem_responder: RTL and testbench

- Word-organised data-memory responder. It is the target end of the CPU core's load/store request/response interface.
- Sits under `top` beside the core. It accepts one request at a time, inserts a configurable number of wait states, then returns read data or a write acknowledgement.
- Gives the core a realistic multi-cycle memory so that pipeline stall logic is exercised in simulation.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word-organised data memory target with
// a configurable number of wait states between request and response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          handshake;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;
  logic [32:0]   offset;
  logic          fault;
  logic [AW-1:0] idx;
  logic          commit;

  // Handshakes, RESP entry and address decode. With zero wait states RESP is
  // entered on the accept edge itself, so the live request is decoded instead
  // of the (not yet loaded) request registers.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    enter_resp = ((state == WAIT) && (cnt == 4'd1)) ||
                 (accept && (WAIT_INIT == 4'd0));
    handshake  = (state == RESP) && rsp_valid && rsp_ready;

    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end

    // 33-bit subtraction: bit 32 set means the address is below BASE_ADDR
    offset = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    fault  = (cur_addr[1:0] != 2'b00) || offset[32] || (offset >= SPAN);
    idx    = offset[AW+1:2];
    commit = enter_resp && cur_we && !fault;
  end

  // Storage: lane-enabled write on the edge entering RESP; never reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) begin
          mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request/response state machine with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= (WAIT_INIT == 4'd0) ? RESP : WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (handshake) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Response payload is fixed at RESP entry and held until the transfer
      if (enter_resp) begin
        rsp_rdata <= (!cur_we && !fault) ? mem[idx] : '0;
        rsp_err   <= fault;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states and one
// with 4 wait states (used for the reset-during-wait scenario).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        valid_a, valid_b;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        rsp_ready;

  logic        ready_a, rv_a, err_a;
  logic [31:0] rdata_a;
  logic        ready_b, rv_b, err_b;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0000_0000)
  ) u_dut (
    .clk      (clk),
    .rst      (rst_a),
    .req_valid(valid_a),
    .req_ready(ready_a),
    .req_we   (we),
    .req_addr (addr),
    .req_wdata(wdata),
    .req_wstrb(wstrb),
    .rsp_valid(rv_a),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rdata_a),
    .rsp_err  (err_a)
  );

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(4),
    .BASE_ADDR  (32'h0000_0000)
  ) u_dut4 (
    .clk      (clk),
    .rst      (rst_b),
    .req_valid(valid_b),
    .req_ready(ready_b),
    .req_we   (we),
    .req_addr (addr),
    .req_wdata(wdata),
    .req_wstrb(wstrb),
    .rsp_valid(rv_b),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rdata_b),
    .rsp_err  (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on the selected instance; lat counts edges from
  // acceptance until rsp_valid is seen.
  task automatic xact(input bit sel, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic e, output int lat);
    int n;
    n = 0;
    while (!(sel ? ready_b : ready_a) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(sel ? ready_b : ready_a), 32'd1);
    we = w; addr = a; wdata = d; wstrb = s;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    lat = 0;
    while (!(sel ? rv_b : rv_a) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? rdata_b : rdata_a;
    e  = sel ? err_b : err_a;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(sel ? rv_b : rv_a), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    rsp_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(ready_a), 32'd0);
    check("rst_rsp_valid", 32'(rv_a), 32'd0);
    check("rst_rsp_rdata", rdata_a, 32'd0);
    check("rst_rsp_err", 32'(err_a), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    check("rdy_first_cycle", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    check("rdy_second_cycle", 32'(ready_a), 32'd1);
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rsp_valid", 32'(rv_a), 32'd0);
    rsp_ready = 1'b0;

    // store then load
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("st_latency", 32'(lat), 32'd3);
    check("st_err", 32'(e), 32'd0);
    check("st_rdata", rd, 32'd0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", 32'(e), 32'd0);

    // single byte lane
    xact(1'b0, 1'b1, 32'h10, 32'h0000_1200, 4'b0010, rd, e, lat);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("lane1_rdata", rd, 32'hDEAD12EF);

    // empty strobe: no update, no error
    xact(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, e, lat);
    check("nostrb_err", 32'(e), 32'd0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("nostrb_rdata", rd, 32'hDEAD12EF);

    // misaligned load
    xact(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, rd, e, lat);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_rdata", rd, 32'd0);

    // out-of-range store must not alias onto word 0
    xact(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, rd, e, lat);
    xact(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, e, lat);
    check("oor_err", 32'(e), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    check("word0_kept", rd, 32'h0BAD_F00D);

    // last valid word
    xact(1'b0, 1'b1, 32'hFFC, 32'h1234_5678, 4'hF, rd, e, lat);
    xact(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, e, lat);
    check("last_rdata", rd, 32'h1234_5678);
    check("last_err", 32'(e), 32'd0);

    // response backpressure; a stray store is presented while busy
    we = 1'b0; addr = 32'h10; valid_a = 1'b1;
    @(posedge clk); #1;
    we = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rv_a), 32'd1);
      check("bp_rdata", rdata_a, 32'hDEAD12EF);
      check("bp_err", 32'(err_a), 32'd0);
      check("bp_req_ready", 32'(ready_a), 32'd0);
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_valid_drop", 32'(rv_a), 32'd0);
    check("bp_req_ready_back", 32'(ready_a), 32'd1);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("busy_ignored", rd, 32'hDEAD12EF);

    // reset during WAIT on the 4-wait-state instance
    xact(1'b1, 1'b1, 32'h20, 32'h1111_1111, 4'hF, rd, e, lat);
    check("w4_latency", 32'(lat), 32'd5);
    we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rv_b), 32'd0);
    check("abort_req_ready", 32'(ready_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check("abort_discard", rd, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
